// File: rtl/mdsa_pkg.sv
`default_nettype none
// ============================================================================
// Package : mdsa_pkg
// Purpose : Shared types and helpers for the mdsa_oe_sorter shear-sort engine.
//           - state_t         : controller states
//           - phase_count()   : number of row/column phases for an N x N sort
//           - pair_select()   : compare pair for a cell on a given step
//           - line_descending(): sort direction of a row or column
// Revision: 1.0 - initial release
// ============================================================================
package mdsa_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ROW  = 3'd2,
    COL  = 3'd3,
    OUT  = 3'd4
  } state_t;

  // One compare pair inside a row or column. lo/hi are the two positions
  // along the line; valid is clear when the pair falls off the end of the line.
  typedef struct packed {
    logic valid;
    int   lo;
    int   hi;
    logic desc;
  } pair_t;

  // ROW, COL repeated ceil(log2 n) times, then one final ROW.
  function automatic int phase_count(input int n);
    return 2 * $clog2(n) + 1;
  endfunction

  // Even steps pair (0,1),(2,3)...; odd steps pair (1,2),(3,4)...
  // Pair k therefore starts at 2k on even steps and 2k+1 on odd steps.
  function automatic pair_t pair_select(input int k, input logic odd_step,
                                        input int n, input logic desc);
    pair_t p;
    int    base;
    base    = 2 * k + (odd_step ? 1 : 0);
    p.valid = (base + 1 < n);
    p.lo    = p.valid ? base : 0;
    p.hi    = p.valid ? base + 1 : 0;
    p.desc  = desc;
    return p;
  endfunction

  // Rows alternate direction (snake); columns all share the global direction.
  function automatic logic line_descending(input logic is_row, input int line,
                                           input logic descend);
    return is_row ? (descend ^ line[0]) : descend;
  endfunction

endpackage : mdsa_pkg
`default_nettype wire

// File: rtl/mdsa_cmp_swap.sv
`default_nettype none
// ============================================================================
// Module  : mdsa_cmp_swap
// Purpose : Combinational compare-exchange cell (unsigned).
//           dir=0 : lo=min(a,b), hi=max(a,b)
//           dir=1 : lo=max(a,b), hi=min(a,b)
//           Swaps only on strict inequality.
// Ports   : a, b   - operands (a from the lower index position)
//           dir    - 1 = descending
//           lo, hi - results for the lower / higher index position
// Revision: 1.0 - initial release
// ============================================================================
module mdsa_cmp_swap #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         dir,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi
);

  logic swap;

  assign swap = dir ? (a < b) : (a > b);
  assign lo   = swap ? b : a;
  assign hi   = swap ? a : b;

endmodule : mdsa_cmp_swap
`default_nettype wire

// File: rtl/mdsa_oe_sorter.sv
`default_nettype none
// ============================================================================
// Module  : mdsa_oe_sorter
// Purpose : N x N shear sort built from odd-even transposition phases.
//           Loads N*N words row-major, sorts in place (ROW/COL phases,
//           then a final ROW), and streams the result in snake or linear order.
// Ports   : clk           - rising-edge clock
//           rst           - asynchronous reset, active low
//           start         - begin transaction (honoured while rdy=1)
//           mode          - 0 snake output, 1 linear output (latched on start)
//           descend       - 0 ascending, 1 descending (latched on start)
//           en            - data_in valid during LOAD
//           data_in       - element, row-major load order
//           rdy           - idle, accepts start
//           output_enable - data_out valid
//           data_out      - sorted element stream
//           done          - one-cycle pulse after the last output word
// Revision: 1.0 - initial release
// ============================================================================
module mdsa_oe_sorter
  import mdsa_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         mode,
  input  logic         descend,
  input  logic         en,
  input  logic [W-1:0] data_in,
  output logic         rdy,
  output logic         output_enable,
  output logic [W-1:0] data_out,
  output logic         done
);

  localparam int IW  = (N > 1) ? $clog2(N) : 1;
  localparam int NPH = phase_count(N);
  localparam int PW  = $clog2(NPH);
  localparam int NP  = N / 2;

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [PW-1:0] LAST_PH  = PW'(NPH - 1);

  function automatic logic [IW-1:0] ix(input int i);
    return IW'(i);
  endfunction

  state_t        state, state_d;
  logic [IW-1:0] step_cnt, step_d;
  logic [PW-1:0] phase_cnt, phase_d;
  logic [IW-1:0] row_cnt, row_d;
  logic [IW-1:0] col_cnt, col_d;
  logic          mode_q, mode_d;
  logic          desc_q, desc_d;
  logic          out_last, out_last_d;
  logic          rdy_d, oe_d, done_d;
  logic [W-1:0]  dout_d;
  logic          load_we, sort_we;
  logic          is_row, odd_step;
  logic [IW-1:0] rd_col;

  logic [W-1:0]  mat     [N][N];
  logic [W-1:0]  mat_nxt [N][N];
  logic [W-1:0]  lo_w    [N][NP];
  logic [W-1:0]  hi_w    [N][NP];
  pair_t         sel;

  assign is_row   = (state == ROW);
  assign odd_step = step_cnt[0];
  // Linear mode reads odd rows right-to-left to undo the snake.
  assign rd_col   = (mode_q && row_cnt[0]) ? (LAST_IDX - col_cnt) : col_cnt;

  // --------------------------------------------------------------------------
  // Compare-exchange array: N lines x N/2 cells. Each cell is muxed onto its
  // even or odd pair and onto a row or a column of the matrix.
  // --------------------------------------------------------------------------
  for (genvar l = 0; l < N; l++) begin : g_line
    for (genvar k = 0; k < NP; k++) begin : g_pair
      localparam int E0 = 2 * k;
      localparam int E1 = 2 * k + 1;
      // On odd steps the last cell of an even-length line has no partner;
      // clamp its indices in range, its result is discarded on write-back.
      localparam int O0 = (2 * k + 2 < N) ? 2 * k + 1 : 2 * k;
      localparam int O1 = (2 * k + 2 < N) ? 2 * k + 2 : 2 * k + 1;

      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         dir;

      always_comb begin
        if (is_row) begin
          a = odd_step ? mat[ix(l)][ix(O0)] : mat[ix(l)][ix(E0)];
          b = odd_step ? mat[ix(l)][ix(O1)] : mat[ix(l)][ix(E1)];
        end else begin
          a = odd_step ? mat[ix(O0)][ix(l)] : mat[ix(E0)][ix(l)];
          b = odd_step ? mat[ix(O1)][ix(l)] : mat[ix(E1)][ix(l)];
        end
        dir = line_descending(is_row, l, desc_q);
      end

      mdsa_cmp_swap #(.W(W)) u_cmp_swap (
        .a  (a),
        .b  (b),
        .dir(dir),
        .lo (lo_w[l][k]),
        .hi (hi_w[l][k])
      );
    end : g_pair
  end : g_line

  // Write the cell results back into their row or column positions.
  always_comb begin
    mat_nxt = mat;
    sel     = '0;
    for (int l = 0; l < N; l++) begin
      for (int k = 0; k < NP; k++) begin
        sel = pair_select(k, odd_step, N, line_descending(is_row, l, desc_q));
        if (sel.valid) begin
          if (is_row) begin
            mat_nxt[ix(l)][ix(sel.lo)] = lo_w[l][k];
            mat_nxt[ix(l)][ix(sel.hi)] = hi_w[l][k];
          end else begin
            mat_nxt[ix(sel.lo)][ix(l)] = lo_w[l][k];
            mat_nxt[ix(sel.hi)][ix(l)] = hi_w[l][k];
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Controller: next-state and next-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state;
    step_d     = step_cnt;
    phase_d    = phase_cnt;
    row_d      = row_cnt;
    col_d      = col_cnt;
    mode_d     = mode_q;
    desc_d     = desc_q;
    out_last_d = out_last;
    load_we    = 1'b0;
    sort_we    = 1'b0;
    oe_d       = 1'b0;
    dout_d     = '0;
    done_d     = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          mode_d  = mode;
          desc_d  = descend;
          row_d   = '0;
          col_d   = '0;
        end
      end

      LOAD: begin
        if (en) begin
          load_we = 1'b1;
          if (col_cnt == LAST_IDX) begin
            col_d = '0;
            if (row_cnt == LAST_IDX) begin
              row_d   = '0;
              step_d  = '0;
              phase_d = '0;
              state_d = ROW;
            end else begin
              row_d = row_cnt + 1'b1;
            end
          end else begin
            col_d = col_cnt + 1'b1;
          end
        end
      end

      ROW, COL: begin
        sort_we = 1'b1;
        if (step_cnt == LAST_IDX) begin
          step_d = '0;
          if (phase_cnt == LAST_PH) begin
            phase_d    = '0;
            row_d      = '0;
            col_d      = '0;
            out_last_d = 1'b0;
            state_d    = OUT;
          end else begin
            phase_d = phase_cnt + 1'b1;
            state_d = (state == ROW) ? COL : ROW;
          end
        end else begin
          step_d = step_cnt + 1'b1;
        end
      end

      OUT: begin
        if (out_last) begin
          // Cycle after the last word: pulse done and go idle together.
          out_last_d = 1'b0;
          done_d     = 1'b1;
          state_d    = IDLE;
        end else begin
          oe_d   = 1'b1;
          dout_d = mat[row_cnt][rd_col];
          if (col_cnt == LAST_IDX) begin
            col_d = '0;
            if (row_cnt == LAST_IDX) begin
              row_d      = '0;
              out_last_d = 1'b1;
            end else begin
              row_d = row_cnt + 1'b1;
            end
          end else begin
            col_d = col_cnt + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    rdy_d = (state_d == IDLE);
  end

  // --------------------------------------------------------------------------
  // Controller registers and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      step_cnt      <= '0;
      phase_cnt     <= '0;
      row_cnt       <= '0;
      col_cnt       <= '0;
      mode_q        <= 1'b0;
      desc_q        <= 1'b0;
      out_last      <= 1'b0;
      rdy           <= 1'b1;
      output_enable <= 1'b0;
      data_out      <= '0;
      done          <= 1'b0;
    end else begin
      state         <= state_d;
      step_cnt      <= step_d;
      phase_cnt     <= phase_d;
      row_cnt       <= row_d;
      col_cnt       <= col_d;
      mode_q        <= mode_d;
      desc_q        <= desc_d;
      out_last      <= out_last_d;
      rdy           <= rdy_d;
      output_enable <= oe_d;
      data_out      <= dout_d;
      done          <= done_d;
    end
  end

  // Matrix storage carries no reset; its contents are only meaningful after
  // a complete load.
  always_ff @(posedge clk) begin
    if (load_we) begin
      mat[row_cnt][col_cnt] <= data_in;
    end else if (sort_we) begin
      mat <= mat_nxt;
    end
  end

endmodule : mdsa_oe_sorter
`default_nettype wire

// File: tb/tb_mdsa_oe_sorter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mdsa_oe_sorter
// Purpose : Self-checking bench for mdsa_oe_sorter (N=4, W=8). A sorted-list
//           reference model fills an expectation queue; a monitor consumes it.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mdsa_oe_sorter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int NN = N * N;

  typedef logic [W-1:0] vec_t [NN];

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         mode;
  logic         descend;
  logic         en;
  logic [W-1:0] data_in;
  logic         rdy;
  logic         output_enable;
  logic [W-1:0] data_out;
  logic         done;

  mdsa_oe_sorter #(.N(N), .W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .mode         (mode),
    .descend      (descend),
    .en           (en),
    .data_in      (data_in),
    .rdy          (rdy),
    .output_enable(output_enable),
    .data_out     (data_out),
    .done         (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  logic [W-1:0] exp_q[$];
  int exp_first   = 0;
  int last_load   = 0;
  int seen        = 0;
  int txns_done   = 0;
  int txns_issued = 0;
  bit expect_done = 1'b0;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: sort the whole input, then lay it out along the snake path.
  // Linear mode emits the sorted list as is; snake mode emits the stored
  // matrix row-major, i.e. odd rows reversed.
  task automatic push_expected(input vec_t v, input logic m, input logic d);
    int s [NN];
    int o [NN];
    int key;
    int j;
    for (int i = 0; i < NN; i++) s[i] = int'(v[i]);
    for (int i = 1; i < NN; i++) begin
      key = s[i];
      j   = i - 1;
      while (j >= 0 && s[j] > key) begin
        s[j+1] = s[j];
        j--;
      end
      s[j+1] = key;
    end
    for (int i = 0; i < NN; i++) o[i] = d ? s[NN-1-i] : s[i];
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (!m && (r % 2 == 1)) exp_q.push_back(W'(o[r*N + (N-1-c)]));
        else                    exp_q.push_back(W'(o[r*N + c]));
      end
    end
    exp_first = last_load + 21;
    txns_issued++;
  endtask

  task automatic load_and_start(input vec_t v, input logic m, input logic d,
                                input int stall_at, output bit ok);
    int w;
    ok = 1'b0;
    w  = 0;
    while (!rdy && w < 200) begin
      tick;
      w++;
    end
    check(rdy == 1'b1, "rdy_before_start", int'(rdy), 1);
    if (!rdy) return;
    start   = 1'b1;
    mode    = m;
    descend = d;
    en      = 1'($urandom);          // must not load on the start edge
    data_in = W'($urandom);
    tick;
    start   = 1'b0;
    mode    = 1'($urandom);          // latched values must be unaffected
    descend = 1'($urandom);
    for (int i = 0; i < NN; i++) begin
      if (i == stall_at) begin
        en = 1'b0;
        repeat (3) begin
          data_in = W'($urandom);
          tick;
        end
      end
      en      = 1'b1;
      data_in = v[i];
      tick;
    end
    last_load = cyc;
    en        = 1'($urandom);        // ignored outside LOAD
    data_in   = W'($urandom);
    ok        = 1'b1;
  endtask

  task automatic wait_done;
    int w;
    w = 0;
    while (txns_done < txns_issued && w < 200) begin
      tick;
      w++;
    end
    check(txns_done == txns_issued, "done_timeout", txns_done, txns_issued);
    txns_done = txns_issued;
  endtask

  // Monitor: consumes expectations whenever the DUT presents output.
  always @(negedge clk) begin
    if (rst) begin
      if (expect_done) begin
        check(done == 1'b1, "done_pulse", int'(done), 1);
        check(rdy == 1'b1, "rdy_with_done", int'(rdy), 1);
        expect_done = 1'b0;
        txns_done++;
      end else begin
        check(done == 1'b0, "spurious_done", int'(done), 0);
      end
      if (seen != 0) check(output_enable == 1'b1, "oe_contiguous", int'(output_enable), 1);
      if (output_enable) begin
        if (seen == 0) check(cyc == exp_first, "first_word_latency", cyc, exp_first);
        check(exp_q.size() > 0, "unexpected_output", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          check(data_out == e, "data_out", int'(data_out), int'(e));
        end
        seen++;
        if (seen == NN) begin
          seen        = 0;
          expect_done = 1'b1;
        end
      end else begin
        seen = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    bit   ok;
    int   j;
    logic [W-1:0] t;
    logic rm, rd;

    rst = 1'b0; start = 1'b0; mode = 1'b0; descend = 1'b0; en = 1'b0; data_in = '0;
    repeat (3) tick;
    check(rdy == 1'b1, "reset_rdy", int'(rdy), 1);
    check(output_enable == 1'b0, "reset_oe", int'(output_enable), 0);
    check(data_out == '0, "reset_data_out", int'(data_out), 0);
    check(done == 1'b0, "reset_done", int'(done), 0);
    rst = 1'b1;
    repeat (2) tick;

    // Reset mid-idle: outputs respond without a clock edge.
    rst = 1'b0;
    #1;
    check(rdy == 1'b1, "idle_reset_rdy", int'(rdy), 1);
    check(output_enable == 1'b0, "idle_reset_oe", int'(output_enable), 0);
    check(data_out == '0, "idle_reset_data_out", int'(data_out), 0);
    #2;
    rst = 1'b1;

    // Linear ascending, reversed input.
    for (int i = 0; i < NN; i++) v[i] = W'(16 - i);
    load_and_start(v, 1'b1, 1'b0, -1, ok);
    if (ok) push_expected(v, 1'b1, 1'b0);
    wait_done;

    // Snake order, same input.
    load_and_start(v, 1'b0, 1'b0, -1, ok);
    if (ok) push_expected(v, 1'b0, 1'b0);
    wait_done;

    // Descending linear, random data.
    repeat (2) begin
      for (int i = 0; i < NN; i++) v[i] = W'($urandom);
      load_and_start(v, 1'b1, 1'b1, -1, ok);
      if (ok) push_expected(v, 1'b1, 1'b1);
      wait_done;
    end

    // All duplicates.
    for (int i = 0; i < NN; i++) v[i] = 8'h55;
    rd = 1'($urandom);
    load_and_start(v, 1'b0, rd, -1, ok);
    if (ok) push_expected(v, 1'b0, rd);
    wait_done;

    // Load stall for 3 cycles mid-load.
    for (int i = 0; i < NN; i++) v[i] = W'($urandom);
    load_and_start(v, 1'b1, 1'b0, 7, ok);
    if (ok) push_expected(v, 1'b1, 1'b0);
    wait_done;

    // start pulsed during a COL phase is ignored.
    for (int i = 0; i < NN; i++) v[i] = W'($urandom);
    load_and_start(v, 1'b1, 1'b0, -1, ok);
    if (ok) push_expected(v, 1'b1, 1'b0);
    repeat (6) tick;
    check(rdy == 1'b0, "rdy_busy", int'(rdy), 0);
    start = 1'b1; mode = 1'b0; descend = 1'b1;
    tick;
    start = 1'b0;
    wait_done;

    // Reset during COL, then a fresh transaction.
    for (int i = 0; i < NN; i++) v[i] = W'($urandom);
    load_and_start(v, 1'b0, 1'b1, -1, ok);
    repeat (7) tick;
    rst = 1'b0;
    #1;
    check(rdy == 1'b1, "sort_reset_rdy", int'(rdy), 1);
    check(output_enable == 1'b0, "sort_reset_oe", int'(output_enable), 0);
    check(data_out == '0, "sort_reset_data_out", int'(data_out), 0);
    check(done == 1'b0, "sort_reset_done", int'(done), 0);
    exp_q.delete();
    seen        = 0;
    expect_done = 1'b0;
    tick;
    rst = 1'b1;
    for (int i = 0; i < NN; i++) v[i] = W'(i);
    for (int i = NN - 1; i > 0; i--) begin
      j    = $urandom_range(0, i);
      t    = v[i];
      v[i] = v[j];
      v[j] = t;
    end
    load_and_start(v, 1'b1, 1'b0, -1, ok);
    if (ok) push_expected(v, 1'b1, 1'b0);
    wait_done;

    // Random mix with duplicates, both orders and directions.
    repeat (6) begin
      for (int i = 0; i < NN; i++) v[i] = W'($urandom_range(0, 15));
      rm = 1'($urandom);
      rd = 1'($urandom);
      load_and_start(v, rm, rd, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 15)) : -1, ok);
      if (ok) push_expected(v, rm, rd);
      wait_done;
    end

    repeat (3) tick;
    check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mdsa_oe_sorter
`default_nettype wire

// File: doc/mdsa_oe_sorter.md
# mdsa_oe_sorter

Parametrised N×N shear-sort engine built from odd-even transposition phases. It succeeds the fixed-size MDSA odd-even sorter under `MDSA_top`. The block loads N·N W-bit words serially, sorts them in place with alternating row and column phases, and streams the result out. A runtime mode selects snake order or a fully linear sorted stream, and a second runtime input selects ascending or descending order.

## Interface
- `N`, 4, matrix rows = columns; N ≥ 2.
- `W`, 8, element width in bits, unsigned compare.
- `clk  in  1`  system clock, rising-edge.
- `rst  in  1`  asynchronous, active-low reset (low = reset).
- `start  in  1`  begin a transaction; honoured only while `rdy`=1.
- `mode  in  1`  0 = snake output order, 1 = linear (globally sorted) order; sampled with `start`.
- `descend  in  1`  0 = ascending, 1 = descending; sampled with `start`.
- `en  in  1`  `data_in` valid during LOAD.
- `data_in  in  W`  element, row-major load order.
- `rdy  out  1`  block idle, accepts `start`.
- `output_enable  out  1`  `data_out` valid.
- `data_out  out  W`  sorted element stream.
- `done  out  1`  one-cycle pulse on the cycle after the last output word.

## Operation
- FSM states:
  - **IDLE:** `rdy`=1. `start`=1 → LOAD, latching `mode` and `descend`.
  - **LOAD:** each edge with `en`=1 writes `data_in` to the next position `(r,c)`, row-major. `en`=0 stalls the load; there is no timeout. After the N·N-th write → ROW.
  - **ROW:** N odd-even transposition steps, one per cycle.
    - Even steps compare pairs (0,1),(2,3)…; odd steps compare (1,2),(3,4)….
    - Row r orders ascending when (r even) XOR `descend`, otherwise descending.
  - **COL:** N steps with the same pairing down each column, ascending top→bottom XOR `descend`.
  - Phase sequence: ROW, COL repeated P = ceil(log2 N) times, then one final ROW, then → OUT.
  - **OUT:** emits N·N words, one per cycle, `output_enable`=1 continuously.
    - mode 0: row-major, snake order as stored.
    - mode 1: odd rows read right→left, giving a monotonic stream.
    - After the last word → IDLE and pulse `done`.
- Compare-exchange swaps only on strict inequality. Equal elements never swap.
- `start` outside IDLE is ignored. `en` outside LOAD is ignored. `mode` and `descend` changes after the latch have no effect.
- Reset at any point:
  - Outputs go to 0 and `rdy` goes to 1 immediately (`rdy`=1, all others 0).
  - FSM returns to IDLE and counters clear.
  - Matrix contents are don't-care.

## Timing
- Reset values: `rdy`=1, `output_enable`=0, `data_out`=0, `done`=0.
- Outputs are registered.
- `start` is sampled at edge t0. Loading begins at edge t0+1.
- Sort latency S = (2P+1)·N cycles, counted from the edge after the last load write.
- First `output_enable`=1 cycle is S+1 cycles after the last load edge. Words then follow on consecutive cycles, with no gaps.
- `rdy` returns to 1 in the same cycle as `done`, so back-to-back transactions are allowed.
- Counters:
  - Step counter: ceil(log2 N) bits.
  - Phase counter: ceil(log2(2P+1)) bits.
  - Element counters: ceil(log2 N) bits each; they wrap at N-1 without overflow.

## Structure
- Package `mdsa_pkg`:
  - `state_t` enum (IDLE, LOAD, ROW, COL, OUT).
  - `phase_count(N)` function returning 2·ceil(log2 N)+1.
  - Pair-select helper that returns partner index and direction for a step.
- Sub-module `mdsa_cmp_swap`: parametrised on W. Inputs a, b, dir; outputs lo, hi. Purely combinational.
- The top instantiates N/2·N cells and muxes them to row or column pairs per phase.

## Test plan
All scenarios use N=4, W=8.
- **Reset:** `rst` low mid-idle → `rdy`=1, `output_enable`=0, `data_out`=0. After release, `start` is accepted next edge.
- **Linear ascending:** load 16,15…1 with mode=1, `descend`=0 → `output_enable` high 16 consecutive cycles, `data_out`=1…16, first word 21 cycles after last load edge, `done` pulse follows.
- **Snake order:** same load with mode=0 → output 1,2,3,4, 8,7,6,5, 9,10,11,12, 16,15,14,13.
- **Descending and duplicates:**
  - Random load with `descend`=1, mode=1 → non-increasing stream that is a permutation of the input.
  - All-0x55 load → sixteen 0x55 words.
- **Load stalls and ignored start:**
  - `en` deasserted for 3 cycles mid-load → load count pauses and the result is unchanged.
  - `start` pulsed during COL → ignored.
- **Reset mid-sort:**
  - `rst` low during COL → outputs zero immediately.
  - After release, a fresh transaction with 0..15 scrambled, mode=1 → 0…15.
